// File: rtl/sys_ctrl_burst_fsm.sv
// Host debug command engine: decodes a UART byte stream into CPU memory bus
// accesses (single/burst read/write) plus halt, run and CPU reset control.
module sys_ctrl_burst_fsm #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              cpu_halt,
  output logic              cpu_rst,
  input  logic              cpu_is_halted,
  output logic              mux_ctrl,
  output logic              busy
);
  localparam int unsigned AB = ADDR_W / 8;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(RST_CYCLES + RD_LAT + 1);
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;
  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_RUN  = 8'h01;
  localparam logic [7:0] OP_WR   = 8'h02;
  localparam logic [7:0] OP_RD   = 8'h03;
  localparam logic [7:0] OP_BWR  = 8'h04;
  localparam logic [7:0] OP_BRD  = 8'h05;
  localparam logic [7:0] OP_CRST = 8'h06;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_LEN, GET_DATA, MEM_WR, MEM_RD,
    RD_WAIT, TX_SEND, TX_WAIT, HALT_WAIT, RST_PULSE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, wdata_q, tx_data_q, reply_val;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        ab_cnt_q;
  logic [8:0]        cnt_q;
  logic [TW-1:0]     tmo_q;
  logic [CW-1:0]     cyc_q;
  logic              cpu_halt_q, mux_q, run_pend_q, tx_ign_q, reply_ld;
  logic              last_ab, tmo_exp, more_rd;

  assign last_ab = (ab_cnt_q == 3'(AB - 1));
  assign tmo_exp = (tmo_q == TW'(TIMEOUT - 1));
  // cnt_q counts bytes still to transfer; a burst read loops back only while the bus is owned
  assign more_rd = (cmd_q == OP_BRD) && mux_q && (cnt_q != 9'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    reply_ld  = 1'b0;
    reply_val = ACK;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        case (rx_data)
          OP_HALT: state_d = HALT_WAIT;
          OP_RUN:  begin state_d = TX_SEND; reply_ld = 1'b1; end
          OP_WR, OP_RD, OP_BWR, OP_BRD: state_d = GET_ADDR;
          OP_CRST: state_d = RST_PULSE;
          default: begin state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK; end
        endcase
      end
      GET_ADDR: begin
        if (rx_valid) begin
          if (last_ab) begin
            if (cmd_q == OP_WR)     state_d = GET_DATA;
            else if (cmd_q != OP_RD) state_d = GET_LEN;
            else if (mux_q)         state_d = MEM_RD;
            else begin state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK; end
          end
        end else if (tmo_exp) begin
          state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK;
        end
      end
      GET_LEN: begin
        if (rx_valid) begin
          if (cmd_q == OP_BWR) state_d = GET_DATA;
          else if (mux_q)      state_d = MEM_RD;
          else begin state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK; end
        end else if (tmo_exp) begin
          state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          if (mux_q) state_d = MEM_WR;
          else if (cnt_q == 9'd1) begin state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK; end
        end else if (tmo_exp) begin
          state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK;
        end
      end
      MEM_WR: begin
        if (cnt_q != 9'd1)       state_d = GET_DATA;
        else if (cmd_q == OP_WR) state_d = IDLE;
        else begin state_d = TX_SEND; reply_ld = 1'b1; end
      end
      MEM_RD:  state_d = RD_WAIT;
      RD_WAIT: if (cyc_q == CW'(RD_LAT - 1)) begin
        state_d = TX_SEND; reply_ld = 1'b1; reply_val = mem_rdata;
      end
      TX_SEND: if (!tx_busy) state_d = TX_WAIT;
      TX_WAIT: if (!tx_ign_q && !tx_busy) state_d = more_rd ? MEM_RD : IDLE;
      HALT_WAIT: begin
        if (cpu_is_halted) begin state_d = TX_SEND; reply_ld = 1'b1; end
        else if (tmo_exp) begin state_d = TX_SEND; reply_ld = 1'b1; reply_val = NAK; end
      end
      RST_PULSE: if (cyc_q == CW'(RST_CYCLES - 1)) begin state_d = TX_SEND; reply_ld = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q <= '0; wdata_q <= '0; tx_data_q <= '0; addr_q <= '0;
      ab_cnt_q <= '0; cnt_q <= '0; tmo_q <= '0; cyc_q <= '0;
      cpu_halt_q <= 1'b0; mux_q <= 1'b0; run_pend_q <= 1'b0; tx_ign_q <= 1'b0;
    end else begin
      tx_ign_q   <= tx_start;
      run_pend_q <= 1'b0;
      if (run_pend_q) cpu_halt_q <= 1'b0;
      if (reply_ld) tx_data_q <= reply_val;
      if (((state_q == GET_ADDR || state_q == GET_LEN || state_q == GET_DATA) && !rx_valid)
          || state_q == HALT_WAIT)
        tmo_q <= tmo_q + TW'(1);
      else
        tmo_q <= '0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0; ab_cnt_q <= '0; cyc_q <= '0;
          if (rx_valid) begin
            cmd_q <= rx_data;
            if (rx_data == OP_HALT) cpu_halt_q <= 1'b1;
            if (rx_data == OP_RUN) begin mux_q <= 1'b0; run_pend_q <= 1'b1; end
            if (rx_data == OP_WR || rx_data == OP_RD) cnt_q <= 9'd1;
          end
        end
        GET_ADDR: if (rx_valid) begin
          addr_q   <= ADDR_W'({addr_q, rx_data});
          ab_cnt_q <= ab_cnt_q + 3'd1;
        end
        GET_LEN:  if (rx_valid) cnt_q <= {1'b0, rx_data} + 9'd1;
        GET_DATA: if (rx_valid) begin
          wdata_q <= rx_data;
          if (!mux_q) cnt_q <= cnt_q - 9'd1;
        end
        MEM_WR, MEM_RD: begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt_q  <= cnt_q - 9'd1;
          cyc_q  <= '0;
        end
        RD_WAIT, RST_PULSE: cyc_q <= cyc_q + CW'(1);
        HALT_WAIT: if (cpu_is_halted) mux_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we    = (state_q == MEM_WR);
    mem_re    = (state_q == MEM_RD);
    cpu_rst   = (state_q == RST_PULSE);
    tx_start  = (state_q == TX_SEND) && !tx_busy;
    busy      = (state_q != IDLE);
    tx_data   = tx_data_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_halt  = cpu_halt_q;
    mux_ctrl  = mux_q;
  end
endmodule

// File: tb/tb_sys_ctrl_burst_fsm.sv
// Scoreboard bench for sys_ctrl_burst_fsm: command-level reference model feeds
// expected TX bytes and memory writes into queues that bus monitors consume.
module tb_sys_ctrl_burst_fsm;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned TIMEOUT    = 400;
  localparam int unsigned RST_CYCLES = 16;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  logic clk = 1'b0;
  logic rst, rx_valid, tx_start, tx_busy, mem_we, mem_re;
  logic cpu_halt, cpu_rst, cpu_is_halted, mux_ctrl, busy;
  logic [7:0] rx_data, tx_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  sys_ctrl_burst_fsm #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .cpu_halt(cpu_halt), .cpu_rst(cpu_rst),
    .cpu_is_halted(cpu_is_halted), .mux_ctrl(mux_ctrl), .busy(busy)
  );

  int compared = 0;
  int fails = 0;
  logic [7:0]  exp_tx[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  ref_mem [0:65535];
  bit mux_m = 1'b0;
  bit cpu_en = 1'b0;
  int re_count = 0;
  int last_pulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Bus-side RAM with RD_LAT read pipeline; data undefined until the pipeline fills
  initial begin : mem_model
    logic [7:0] ram [0:65535];
    logic [7:0] pipe [RD_LAT];
    logic we, re;
    logic [15:0] a;
    logic [7:0] d;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    for (int i = 0; i < int'(RD_LAT); i++) pipe[i] = 8'h00;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      we = mem_we; re = mem_re; a = mem_addr; d = mem_wdata;
      @(posedge clk);
      #1;
      if (we) ram[a] = d;
      for (int i = int'(RD_LAT) - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = re ? ram[a] : 8'hxx;
      mem_rdata = pipe[RD_LAT-1];
    end
  end

  initial begin : uart_tx
    logic [7:0] e;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (tx_busy) begin compared++; fails++; $display("FAIL tx_start_while_busy: tx_busy=1, required 0"); end
        if (exp_tx.size() == 0) begin
          compared++; fails++;
          $display("FAIL tx_unexpected: byte 0x%0h, no reply required", tx_data);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e));
        end
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin : bus_mon
    logic [23:0] e;
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (mem_we && mem_re) begin
        compared++; fails++;
        $display("FAIL we_re_overlap: both strobes 1, required at most one");
      end
      if (mem_re) re_count++;
      if (cpu_rst) run++;
      else if (run > 0) begin last_pulse = run; run = 0; end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          compared++; fails++;
          $display("FAIL wr_unexpected: addr 0x%0h data 0x%0h, no write required", mem_addr, mem_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[23:8]));
          chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin : cpu_model
    logic [4:0] sr;
    sr = '0;
    cpu_is_halted = 1'b0;
    forever begin
      @(negedge clk);
      sr = {sr[3:0], cpu_halt};
      cpu_is_halted = cpu_en && sr[4];
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    repeat ($urandom_range(2, 12)) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) begin
      compared++; fails++;
      $display("FAIL %s_idle: %0d tx / %0d wr outstanding busy=%0b, required none", name,
               exp_tx.size(), exp_wr.size(), busy);
      exp_tx.delete(); exp_wr.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd_simple(input logic [7:0] op, input logic [7:0] reply);
    exp_tx.push_back(reply);
    send_byte(op);
    wait_idle("simple");
  endtask

  task automatic cmd_write(input logic [15:0] a, input logic [7:0] d);
    if (mux_m) begin exp_wr.push_back({a, d}); ref_mem[a] = d; end
    else exp_tx.push_back(NAK);
    send_byte(8'h02); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(d);
    wait_idle("write");
  endtask

  task automatic cmd_read(input logic [15:0] a);
    exp_tx.push_back(mux_m ? ref_mem[a] : NAK);
    send_byte(8'h03); send_byte(a[15:8]); send_byte(a[7:0]);
    wait_idle("read");
  endtask

  task automatic cmd_bwr(input logic [15:0] a, input logic [7:0] dq[$]);
    logic [15:0] aa;
    for (int i = 0; i < dq.size(); i++) begin
      aa = a + 16'(i);
      if (mux_m) begin exp_wr.push_back({aa, dq[i]}); ref_mem[aa] = dq[i]; end
    end
    exp_tx.push_back(mux_m ? ACK : NAK);
    send_byte(8'h04); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(8'(dq.size() - 1));
    for (int i = 0; i < dq.size(); i++) send_byte(dq[i]);
    wait_idle("burst_wr");
  endtask

  task automatic cmd_brd(input logic [15:0] a, input int n);
    if (mux_m) for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[a + 16'(i)]);
    else exp_tx.push_back(NAK);
    send_byte(8'h05); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(8'(n - 1));
    wait_idle("burst_rd");
  endtask

  initial begin : main
    logic [7:0] dq[$];
    logic [15:0] a;
    int n, re_before;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_cpu_halt", 32'(cpu_halt), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 0);
    chk("rst_mux_ctrl", 32'(mux_ctrl), 0);
    chk("rst_busy", 32'(busy), 0);

    cmd_simple(8'h09, NAK);
    cmd_simple(8'h00, NAK);                  // CPU never acknowledges
    chk("halt_tmo_cpu_halt", 32'(cpu_halt), 1);
    chk("halt_tmo_mux", 32'(mux_ctrl), 0);
    cmd_simple(8'h01, ACK);
    chk("run_mux", 32'(mux_ctrl), 0);
    chk("run_cpu_halt", 32'(cpu_halt), 0);
    cpu_en = 1'b1;
    cmd_simple(8'h00, ACK);
    mux_m = 1'b1;
    chk("halt_cpu_halt", 32'(cpu_halt), 1);
    chk("halt_mux", 32'(mux_ctrl), 1);

    cmd_write(16'h1234, 8'h5A);
    cmd_read(16'h1234);
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmd_bwr(16'hFFFE, dq);
    cmd_brd(16'hFFFE, 4);

    cmd_simple(8'h06, ACK);
    chk("cpu_rst_len", 32'(last_pulse), RST_CYCLES);
    chk("cpu_rst_halt_kept", 32'(cpu_halt), 1);
    chk("cpu_rst_mux_kept", 32'(mux_ctrl), 1);

    exp_tx.push_back(NAK);
    send_byte(8'h03); send_byte(8'h00);
    repeat (TIMEOUT + 50) @(negedge clk);
    chk("tmo_reply_pending", 32'(exp_tx.size()), 0);
    chk("tmo_busy", 32'(busy), 0);
    wait_idle("timeout");
    cmd_read(16'h0000);

    for (int it = 0; it < 25; it++) begin
      a = 16'hFFF0 + 16'($urandom_range(0, 31));
      n = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0: cmd_write(a, 8'($urandom));
        1: cmd_read(a);
        2: begin
          dq.delete();
          for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
          cmd_bwr(a, dq);
        end
        default: cmd_brd(a, n);
      endcase
    end

    cmd_simple(8'h01, ACK);
    mux_m = 1'b0;
    chk("run2_mux", 32'(mux_ctrl), 0);
    re_before = re_count;
    cmd_write(16'h0010, 8'h77);
    cmd_read(16'h0010);
    cmd_brd(16'h0010, 3);
    dq = '{8'h01, 8'h02};
    cmd_bwr(16'h0010, dq);
    chk("nomux_no_reads", 32'(re_count), 32'(re_before));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end
endmodule
